// File: rtl/all_gates.sv
// all_gates: two-input gate unit with a clocked monitor.
// The seven gate outputs are pure combinational functions of a and b.
// The monitor snapshots them every clock, records which {a,b}
// combinations have been seen, and flags any disagreement between the
// snapshot and a recomputation from the registered operands.
module all_gates (
    output logic       and_out,
    output logic       nand_out,
    output logic       or_out,
    output logic       nor_out,
    output logic       xor_out,
    output logic       xnor_out,
    output logic       not_out,
    input  logic       a,
    input  logic       b,
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] gate_q,
    output logic [3:0] cov,
    output logic       cov_done,
    output logic       chk_err
);

    // Reference vector used by the self-check, ordered like gate_q:
    // bit 6 = and ... bit 0 = not.
    function automatic logic [6:0] expected_vec(input logic ea, input logic eb);
        logic and_v;
        logic or_v;
        logic xor_v;
        and_v = ea & eb;
        or_v  = ea | eb;
        xor_v = ea ^ eb;
        return {and_v, ~and_v, or_v, ~or_v, xor_v, ~xor_v, ~ea};
    endfunction

    logic [6:0] gate_vec;
    logic [6:0] gate_q_reg;
    logic       a_reg;
    logic       b_reg;
    logic       valid_reg;
    logic       chk_err_reg;
    logic [3:0] cov_reg;
    logic [1:0] ab_sel;

    assign ab_sel = {a, b};

    // Combinational gates: zero latency, unaffected by clock or reset.
    assign and_out  = a & b;
    assign nand_out = ~(a & b);
    assign or_out   = a | b;
    assign nor_out  = ~(a | b);
    assign xor_out  = a ^ b;
    assign xnor_out = ~(a ^ b);
    assign not_out  = ~a;

    assign gate_vec = {and_out, nand_out, or_out, nor_out, xor_out, xnor_out, not_out};

    // Snapshot of the gate outputs together with the operands that produced them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q_reg <= 7'd0;
            a_reg      <= 1'b0;
            b_reg      <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            gate_q_reg <= gate_vec;
            a_reg      <= a;
            b_reg      <= b;
            valid_reg  <= 1'b1;
        end
    end

    // Sticky coverage: one bit per {a,b} combination, cleared only by reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cov
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cov_reg[gi] <= 1'b0;
                end else if (ab_sel == gi[1:0]) begin
                    cov_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Sticky self-check: once a snapshot exists, compare it against the
    // vector recomputed from the operands captured on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_reg <= 1'b0;
        end else if (valid_reg && (gate_q_reg != expected_vec(a_reg, b_reg))) begin
            chk_err_reg <= 1'b1;
        end
    end

    assign gate_q   = gate_q_reg;
    assign cov      = cov_reg;
    assign cov_done = &cov_reg;
    assign chk_err  = chk_err_reg;

endmodule

// File: tb/tb_all_gates.sv
// Directed and randomized bench for all_gates, checked against a
// truth-table model computed arithmetically from the operands.
module tb_all_gates;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       and_out, nand_out, or_out, nor_out, xor_out, xnor_out, not_out;
    logic [6:0] gate_q;
    logic [3:0] cov;
    logic       cov_done;
    logic       chk_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic [3:0] cov_model;
    logic [6:0] prev_vec;

    all_gates dut (
        .and_out  (and_out),
        .nand_out (nand_out),
        .or_out   (or_out),
        .nor_out  (nor_out),
        .xor_out  (xor_out),
        .xnor_out (xnor_out),
        .not_out  (not_out),
        .a        (a),
        .b        (b),
        .clk      (clk),
        .rst_n    (rst_n),
        .gate_q   (gate_q),
        .cov      (cov),
        .cov_done (cov_done),
        .chk_err  (chk_err)
    );

    // Clock runs only while clk_en is set (period 10).
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    logic [6:0] comb_vec;
    assign comb_vec = {and_out, nand_out, or_out, nor_out, xor_out, xnor_out, not_out};

    // Truth-table row from plain arithmetic on the operand values.
    function automatic logic [6:0] model_vec(input logic ma, input logic mb);
        int sum;
        logic and_v, or_v, xor_v;
        sum   = int'(ma) + int'(mb);
        and_v = (sum == 2);
        or_v  = (sum >= 1);
        xor_v = (sum == 1);
        return {and_v, !and_v, or_v, !or_v, xor_v, !xor_v, !ma};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply operands, take an edge, update the model.
    task automatic step(input logic na, input logic nb);
        a = na;
        b = nb;
        tick();
        prev_vec = model_vec(na, nb);
        cov_model[{na, nb}] = 1'b1;
    endtask

    initial begin
        clk_en    = 1'b0;
        rst_n     = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        cov_model = 4'd0;
        prev_vec  = 7'd0;

        // Combinational sweep with no clock.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            a  = ab[1];
            b  = ab[0];
            #10;
            $display("sweep ab=%b%b gates=%b", a, b, comb_vec);
            check("sweep_gates", {1'b0, comb_vec}, {1'b0, model_vec(ab[1], ab[0])});
        end
        check("sweep_gate_q", {1'b0, gate_q}, 8'd0);
        check("sweep_cov", {4'd0, cov}, 8'd0);

        // Reset held with clock running and a=b=1.
        a = 1'b1;
        b = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("reset cycle %0d gate_q=%b cov=%b", i, gate_q, cov);
            check("rst_gate_q", {1'b0, gate_q}, 8'd0);
            check("rst_cov", {4'd0, cov}, 8'd0);
            check("rst_chk_err", {7'd0, chk_err}, 8'd0);
            check("rst_cov_done", {7'd0, cov_done}, 8'd0);
            check("rst_and_out", {7'd0, and_out}, 8'd1);
            check("rst_not_out", {7'd0, not_out}, 8'd0);
        end

        // Release reset, first capture latency.
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        $display("capture ab=01 gate_q=%b cov=%b", gate_q, cov);
        check("cap_gate_q", {1'b0, gate_q}, 8'b0011_0101);
        check("cap_cov", {4'd0, cov}, 8'b0000_0010);

        // Coverage over all four combinations.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            step(ab[1], ab[0]);
            $display("cover ab=%b cov=%b cov_done=%b", ab, cov, cov_done);
            check("cov_bits", {4'd0, cov}, {4'd0, cov_model});
            check("cov_gate_q", {1'b0, gate_q}, {1'b0, prev_vec});
        end
        check("cov_done", {7'd0, cov_done}, 8'd1);
        step(1'b0, 1'b0);
        $display("cover back to 00 cov=%b", cov);
        check("cov_sticky", {4'd0, cov}, 8'h0f);

        // Mid-operation asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset gate_q=%b cov=%b cov_done=%b", gate_q, cov, cov_done);
        check("mid_rst_cov", {4'd0, cov}, 8'd0);
        check("mid_rst_gate_q", {1'b0, gate_q}, 8'd0);
        check("mid_rst_cov_done", {7'd0, cov_done}, 8'd0);
        check("mid_rst_gates", {1'b0, comb_vec}, {1'b0, model_vec(a, b)});
        #1;
        rst_n = 1'b1;
        cov_model = 4'd0;

        // Random run: snapshot tracks previous inputs, self-check stays clear.
        for (int i = 0; i < 1000; i++) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            step(ra, rb);
            check("rnd_gate_q", {1'b0, gate_q}, {1'b0, prev_vec});
            check("rnd_gates", {1'b0, comb_vec}, {1'b0, model_vec(ra, rb)});
            check("rnd_cov", {4'd0, cov}, {4'd0, cov_model});
            check("rnd_chk_err", {7'd0, chk_err}, 8'd0);
        end
        $display("random run done cov=%b chk_err=%b", cov, chk_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
